// File: rtl/tick_gen.sv
// Timebase generator: a programmable prescaler that emits single-cycle enable ticks on clk,
// plus NUM_CH sub-divided channels, each with a tick and a square-wave output.
module tick_gen #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned DEFAULT_DIV = 10_000_000,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned SUB_W       = 4,
    parameter int unsigned DEFAULT_SUB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_sel,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic              base_tick,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_sq
);

    localparam logic [3:0]       MAX_SEL = 4'(NUM_CH);
    localparam logic [CNT_W-1:0] ONE_P   = CNT_W'(1);
    localparam logic [SUB_W-1:0] ONE_S   = SUB_W'(1);

    logic [CNT_W-1:0]             pcnt_q, pcnt_d, div_q, div_d, p_last;
    logic [NUM_CH-1:0][SUB_W-1:0] scnt_q, scnt_d, sub_q, sub_d, s_last;
    logic [NUM_CH-1:0]            ch_term;
    logic                         wrap;
    logic                         base_q, base_d;
    logic [NUM_CH-1:0]            ch_tick_q, ch_tick_d, ch_sq_q, ch_sq_d;
    logic                         pend_q, pend_d, do_apply;
    logic [3:0]                   psel_q, psel_d;
    logic [CNT_W-1:0]             pdata_q, pdata_d;

    // A zero divisor or ratio behaves as 1.
    always_comb begin
        p_last = (div_q == '0) ? '0 : div_q - ONE_P;
        wrap   = en && (pcnt_q == p_last);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            s_last[k]  = (sub_q[k] == '0) ? '0 : sub_q[k] - ONE_S;
            ch_term[k] = wrap && (scnt_q[k] == s_last[k]);
        end
    end

    // Pending update lands on the target's own wrap so the running period completes at its
    // old length; a clear or a stalled count applies it straight away.
    always_comb begin
        do_apply = 1'b0;
        if (pend_q) begin
            if (sync_clr || !en) begin
                do_apply = 1'b1;
            end else if (psel_q == '0) begin
                do_apply = wrap;
            end else begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (psel_q == 4'(k + 1)) begin
                        do_apply = ch_term[k];
                    end
                end
            end
        end
    end

    always_comb begin
        pcnt_d    = pcnt_q;
        scnt_d    = scnt_q;
        div_d     = div_q;
        sub_d     = sub_q;
        base_d    = 1'b0;
        ch_tick_d = '0;
        ch_sq_d   = ch_sq_q;
        pend_d    = pend_q;
        psel_d    = psel_q;
        pdata_d   = pdata_q;

        if (sync_clr) begin
            pcnt_d  = '0;
            scnt_d  = '0;
            ch_sq_d = '0;
        end else if (en) begin
            if (wrap) begin
                pcnt_d = '0;
                base_d = 1'b1;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (ch_term[k]) begin
                        scnt_d[k]    = '0;
                        ch_tick_d[k] = 1'b1;
                        ch_sq_d[k]   = ~ch_sq_q[k];
                    end else begin
                        scnt_d[k] = scnt_q[k] + ONE_S;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + ONE_P;
            end
        end

        if (do_apply) begin
            pend_d = 1'b0;
            if (psel_q == '0) begin
                div_d = pdata_q;
                if (!en) pcnt_d = '0;
            end
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (psel_q == 4'(k + 1)) begin
                    sub_d[k] = pdata_q[SUB_W-1:0];
                    if (!en) scnt_d[k] = '0;
                end
            end
        end

        // Out-of-range targets are accepted and dropped, so the slot never closes for them.
        if (!sync_clr && cfg_valid && !pend_q && (cfg_sel <= MAX_SEL)) begin
            pend_d  = 1'b1;
            psel_d  = cfg_sel;
            pdata_d = cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q    <= '0;
            scnt_q    <= '0;
            div_q     <= CNT_W'(DEFAULT_DIV);
            sub_q     <= {NUM_CH{SUB_W'(DEFAULT_SUB)}};
            base_q    <= 1'b0;
            ch_tick_q <= '0;
            ch_sq_q   <= '0;
            pend_q    <= 1'b0;
            psel_q    <= '0;
            pdata_q   <= '0;
        end else begin
            pcnt_q    <= pcnt_d;
            scnt_q    <= scnt_d;
            div_q     <= div_d;
            sub_q     <= sub_d;
            base_q    <= base_d;
            ch_tick_q <= ch_tick_d;
            ch_sq_q   <= ch_sq_d;
            pend_q    <= pend_d;
            psel_q    <= psel_d;
            pdata_q   <= pdata_d;
        end
    end

    assign cfg_ready = ~pend_q;
    assign base_tick = base_q;
    assign ch_tick   = ch_tick_q;
    assign ch_sq     = ch_sq_q;

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised timebase generator for the traffic-light controller. Replaces a fixed divide-by-N toggled clock with single-cycle enable ticks on the system clock, plus NUM_CH sub-divided channels, for example a 1 Hz state timer and a 2 Hz blink.

- Prescaler divisor and per-channel ratios are programmable at run time through a valid/ready port.
- A sync-clear input re-phases all counters.
- All logic stays in the clk domain; no derived clocks.

## Interface
- CNT_W, 24: prescaler counter and divisor width.
- DEFAULT_DIV, 10_000_000: prescaler period in clk cycles after reset. Must fit in CNT_W.
- NUM_CH, 2: number of sub-divided channels, 1..15.
- SUB_W, 4: channel counter and ratio width.
- DEFAULT_SUB, 1: ratio loaded into every channel at reset.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- sync_clr  in  1  synchronous re-phase of all counters.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration slot free.
- cfg_sel  in  4  target: 0 = prescaler; k = channel k-1 (1..NUM_CH).
- cfg_data  in  CNT_W  new divisor. Channels use the low SUB_W bits.
- base_tick  out  1  one-cycle pulse per prescaler period.
- ch_tick  out  NUM_CH  one-cycle pulse per channel period.
- ch_sq  out  NUM_CH  square wave; toggles on each ch_tick.

## Operation
- **Effective periods.**
  - Prescaler period P = max(div_q, 1).
  - Channel k period S_k = max(sub_q[k], 1), counted in base ticks.
- **Prescaler.** pcnt counts enabled clk edges 0..P-1.
  - On the edge where pcnt == P-1 and en == 1: pcnt <= 0 and base_tick <= 1.
  - On every other edge base_tick <= 0.
- **Channels.** scnt[k] advances only on edges where the prescaler wraps.
  - On the wrap edge with scnt[k] == S_k-1: scnt[k] <= 0, ch_tick[k] <= 1 and ch_sq[k] <= ~ch_sq[k].
  - ch_tick[k] is therefore coincident with the base_tick that completes the channel period.
- **en = 0.** All counters hold, all ticks are 0, ch_sq holds.
- **Configuration: a single pending slot shared by all targets.**
  - cfg_ready == 1 only when no update is pending.
  - Accept when cfg_valid & cfg_ready: latch sel/data and clear cfg_ready on that edge.
  - The pending value is applied on the target's wrap edge (prescaler wrap for sel 0; channel terminal wrap for sel k), so the current period always completes at its old length.
  - On the apply edge cfg_ready <= 1.
  - If en == 0 while pending, apply on the next edge and clear the target counter to 0.
  - cfg_sel > NUM_CH: the request is accepted and discarded; cfg_ready stays 1.
- **sync_clr.** Has priority over counting and config waiting. On the sync_clr edge:
  - All counters <= 0; all ticks <= 0; ch_sq <= 0.
  - Any pending update is applied and cfg_ready <= 1.
  - A cfg request presented in the same cycle is accepted after the clear, on the next edge.
- **Simultaneous accept and apply.** An accept and an apply cannot occur on the same edge, because accept requires cfg_ready == 1.
- **Reset values.**
  - pcnt = 0, scnt = 0, div_q = DEFAULT_DIV, sub_q = DEFAULT_SUB for all channels.
  - base_tick = 0, ch_tick = 0, ch_sq = 0, cfg_ready = 1, pending = 0.
  - A pending update is lost on reset.

## Timing
- **Output registers.** All outputs are registered; there is no combinational input-to-output path.
- **Tick latency.** Number the edges with en == 1 from the first as 1. base_tick is high after edge P, 2P, 3P, …
- **Tick width.** base_tick is high for exactly one cycle when P ≥ 2. With P = 1 it is continuously high while en == 1.
- **Channel ticks.** ch_tick[k] is high after edge P·S_k·n.
  - ch_sq[k] changes on the same edge that raises ch_tick[k].
- **en gaps.** Each cycle with en == 0 delays all subsequent ticks by one cycle.
- **Reconfiguration.**
  - The new period takes effect immediately after the apply edge.
  - The first new-period tick follows the apply edge by P_new edges.
  - cfg_ready is low from the edge after acceptance through the apply edge, and high the cycle after.
- **Reset release.** Counting starts on the first edge with rst_n high and en high.

## Test plan
All scenarios use DEFAULT_DIV = 5, DEFAULT_SUB = 2, NUM_CH = 2, en = 1 unless stated.

1. **Reset then run:** base_tick after edges 5, 10, 15, 20. ch_tick after edges 10 and 20. ch_sq rises at edge 10 and falls at edge 20.
2. **Prescaler reconfig:** accept sel 0, data 3 at edge 2. cfg_ready low until edge 5. base_tick at 5, 8, 11. cfg_ready high from edge 5.
3. **Channel reconfig:** sel 2, data 0x13 (low bits 3 → ratio 3). Channel 1 finishes its current 2-tick period, then ticks every 15 edges. Channel 0 is unaffected.
4. **Enable gap:** en low for 4 cycles after edge 3. base_tick at 9, 14. ticks are 0 and ch_sq holds during the gap.
5. **Divisor edge cases:** prescaler divisor 0 → base_tick continuously high. Channel ratio 1 → ch_tick == base_tick and ch_sq toggles every cycle.
6. **Clear and reset mid-operation:**
   - sync_clr at edge 7 → next base_tick at edge 12 and ch_sq = 0.
   - rst_n asserted with an update pending → all outputs reset immediately, cfg_ready = 1, and the period reverts to 5.
